// File: rtl/pipeline_control_unit_if.sv
// ID-stage control bundle: decode/hazard inputs in, control word and pipeline enables out.
interface pipeline_control_unit_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  id_valid_i;
    logic [6:0]            op_i;
    logic [6:0]            funct7_i;
    logic [REG_ADDR_W-1:0] rs1_i;
    logic [REG_ADDR_W-1:0] rs2_i;
    logic [REG_ADDR_W-1:0] id_ex_rd_i;
    logic                  id_ex_mem_read_i;
    logic                  branch_taken_i;

    logic                  branch_o;
    logic                  mem_read_o;
    logic                  mem_to_reg_o;
    logic                  mem_write_o;
    logic                  alu_src_o;
    logic                  reg_write_o;
    logic [2:0]            alu_op_o;
    logic                  pc_write_o;
    logic                  if_id_write_o;
    logic                  if_id_flush_o;
    logic                  mul_busy_o;
    logic                  illegal_o;

    modport master (
        output id_valid_i, op_i, funct7_i, rs1_i, rs2_i, id_ex_rd_i,
               id_ex_mem_read_i, branch_taken_i,
        input  branch_o, mem_read_o, mem_to_reg_o, mem_write_o, alu_src_o,
               reg_write_o, alu_op_o, pc_write_o, if_id_write_o,
               if_id_flush_o, mul_busy_o, illegal_o
    );

    modport slave (
        input  id_valid_i, op_i, funct7_i, rs1_i, rs2_i, id_ex_rd_i,
               id_ex_mem_read_i, branch_taken_i,
        output branch_o, mem_read_o, mem_to_reg_o, mem_write_o, alu_src_o,
               reg_write_o, alu_op_o, pc_write_o, if_id_write_o,
               if_id_flush_o, mul_busy_o, illegal_o
    );
endinterface

// File: rtl/pipeline_control_unit.sv
// ID-stage control: opcode decode plus load-use stall, multi-cycle MUL stall and branch flush.
module pipeline_control_unit #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned MUL_LAT     = 4,
    parameter int unsigned FLUSH_DEPTH = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    pipeline_control_unit_if.slave        bus
);
    localparam int unsigned CNT_MAX = (MUL_LAT > FLUSH_DEPTH) ? MUL_LAT : FLUSH_DEPTH;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IALU   = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] F7_MUL    = 7'h01;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {ST_RUN, ST_MUL_WAIT, ST_FLUSH} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;

    logic [8:0] dec_word_c, word_c;
    logic       legal_c, uses_rs1_c, uses_rs2_c, hazard_c, is_mul_c;
    logic       pc_write_c, if_id_write_c, if_id_flush_c;

    // Word order: {branch, mem_to_reg, reg_write, mem_read, mem_write, alu_src, alu_op[2:0]}
    always_comb begin
        dec_word_c = '0;
        legal_c    = 1'b1;
        uses_rs1_c = 1'b1;
        uses_rs2_c = 1'b0;
        case (bus.op_i)
            OP_R:      begin dec_word_c = 9'b0_0_1_0_0_0_000; uses_rs2_c = 1'b1; end
            OP_IALU:         dec_word_c = 9'b0_0_1_0_0_1_001;
            OP_LUI:    begin dec_word_c = 9'b0_0_1_0_0_1_010; uses_rs1_c = 1'b0; end
            OP_LOAD:         dec_word_c = 9'b0_1_1_1_0_1_011;
            OP_STORE:  begin dec_word_c = 9'b0_0_0_0_1_1_100; uses_rs2_c = 1'b1; end
            OP_BRANCH: begin dec_word_c = 9'b1_0_0_0_0_1_101; uses_rs2_c = 1'b1; end
            OP_JALR:         dec_word_c = 9'b1_0_1_0_0_1_110;
            OP_JAL:    begin dec_word_c = 9'b1_0_1_0_0_1_111; uses_rs1_c = 1'b0; end
            default:         legal_c    = 1'b0;
        endcase
        if (!bus.id_valid_i) begin
            dec_word_c = '0;
        end
    end

    assign hazard_c = bus.id_ex_mem_read_i && (bus.id_ex_rd_i != ZERO_REG) &&
                      ((uses_rs1_c && (bus.id_ex_rd_i == bus.rs1_i)) ||
                       (uses_rs2_c && (bus.id_ex_rd_i == bus.rs2_i)));
    assign is_mul_c = bus.id_valid_i && (bus.op_i == OP_R) && (bus.funct7_i == F7_MUL);

    // Sequencing: flush beats MUL wait beats load-use beats normal issue.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        illegal_d     = bus.id_valid_i && !legal_c;
        word_c        = dec_word_c;
        pc_write_c    = 1'b1;
        if_id_write_c = 1'b1;
        if_id_flush_c = 1'b0;
        if (bus.branch_taken_i) begin
            word_c        = '0;
            if_id_flush_c = 1'b1;
            if (FLUSH_DEPTH > 1) begin
                state_d = ST_FLUSH;
                cnt_d   = CNT_W'(FLUSH_DEPTH - 1);
            end else begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    word_c        = '0;
                    if_id_flush_c = 1'b1;
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_MUL_WAIT: begin
                    word_c        = '0;
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    if (hazard_c) begin
                        word_c        = '0;
                        pc_write_c    = 1'b0;
                        if_id_write_c = 1'b0;
                    end else if (is_mul_c && (MUL_LAT > 1)) begin
                        state_d = ST_MUL_WAIT;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign {bus.branch_o, bus.mem_to_reg_o, bus.reg_write_o, bus.mem_read_o,
            bus.mem_write_o, bus.alu_src_o, bus.alu_op_o} = word_c;
    assign bus.pc_write_o    = pc_write_c;
    assign bus.if_id_write_o = if_id_write_c;
    assign bus.if_id_flush_o = if_id_flush_c;
    assign bus.mul_busy_o    = (state_q == ST_MUL_WAIT);
    assign bus.illegal_o     = illegal_q;
endmodule
